// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver with runtime baud divider; define UART_RX_PARITY_EN for an even-parity bit and parity_error.
`timescale 1ns/1ps
module uart_rx_core #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  UART_RX,
    input  logic [31:0]           baud_rate,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_done,
    output logic                  frame_error,
    output logic                  rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_error
`endif
);

    localparam logic [31:0] CLK_FREQ_W   = 32'(CLK_FREQ);
    localparam logic [31:0] RESET_PERIOD = 32'(CLK_FREQ / 9600);
    localparam int          BW           = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t state_q, state_d;

    // Reset asserts at once but releases only after two clock edges.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rst_sync <= 2'b00;
        else                rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [1:0] rx_sync;
    logic       rx_s;
    always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], UART_RX};
    end
    assign rx_s = rx_sync[1];

    logic [31:0] last_baud, pend_baud, divisor, bit_period, div_rem, div_quo, rem_diff;
    logic [32:0] rem_sh;
    logic [5:0]  div_cnt;
    logic        pend_valid, div_busy, div_start, new_baud, take;

    assign new_baud  = (baud_rate != 32'd0) && (baud_rate != last_baud);
    assign div_start = pend_valid && !div_busy && (state_q == IDLE);
    assign rem_sh    = {div_rem, div_quo[31]};
    assign take      = rem_sh >= {1'b0, divisor};
    assign rem_diff  = rem_sh[31:0] - divisor;

    always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
        if (!rst_n) begin
            last_baud  <= 32'd9600;
            pend_baud  <= 32'd9600;
            pend_valid <= 1'b0;
            div_busy   <= 1'b0;
            div_cnt    <= '0;
            divisor    <= 32'd1;
            div_rem    <= '0;
            div_quo    <= '0;
            bit_period <= RESET_PERIOD;
        end else begin
            // A value arriving while dividing leaves pend_valid set, so it reruns afterwards.
            if (new_baud) begin
                pend_baud  <= baud_rate;
                last_baud  <= baud_rate;
                pend_valid <= 1'b1;
            end else if (div_start) begin
                pend_valid <= 1'b0;
            end
            if (div_start) begin
                div_busy <= 1'b1;
                div_cnt  <= '0;
                divisor  <= pend_baud;
                div_rem  <= '0;
                div_quo  <= CLK_FREQ_W;
            end else if (div_busy) begin
                if (div_cnt == 6'd32) begin
                    div_busy   <= 1'b0;
                    bit_period <= (div_quo < 32'd2) ? 32'd2 : div_quo;
                end else begin
                    div_rem <= take ? rem_diff : rem_sh[31:0];
                    div_quo <= {div_quo[30:0], take};
                    div_cnt <= div_cnt + 6'd1;
                end
            end
        end
    end

    logic [31:0]           cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  armed, half_hit, full_hit;
    logic                  cnt_clr, sample_bit, finish;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit, par_sample;
`endif

    assign half_hit = cnt == ((bit_period >> 1) - 32'd1);
    assign full_hit = cnt == (bit_period - 32'd1);

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        sample_bit = 1'b0;
        finish     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
`endif
        case (state_q)
            IDLE: if (armed && !rx_s && !div_busy && !pend_valid) begin
                state_d = START;
                cnt_clr = 1'b1;
            end
            START: if (half_hit) begin
                cnt_clr = 1'b1;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (full_hit) begin
                cnt_clr    = 1'b1;
                sample_bit = 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_idx == LAST_BIT) state_d = PARITY;
`else
                if (bit_idx == LAST_BIT) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (full_hit) begin
                cnt_clr    = 1'b1;
                par_sample = 1'b1;
                state_d    = STOP;
            end
`endif
            STOP: if (full_hit) begin
                cnt_clr = 1'b1;
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            armed       <= 1'b0;
            rx_data     <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt     <= (cnt_clr || state_q == IDLE) ? 32'd0 : cnt + 32'd1;
            // A low stop bit leaves the receiver disarmed until the line idles high.
            if (finish)                        armed <= rx_s;
            else if (state_q == IDLE && rx_s)  armed <= 1'b1;
            if (state_q == START)              bit_idx <= '0;
            else if (sample_bit)               bit_idx <= bit_idx + 1'b1;
            if (sample_bit)                    shift <= {rx_s, shift[DATA_WIDTH-1:1]};
            rx_done <= finish;
            if (finish) begin
                rx_data     <= shift;
                frame_error <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                parity_error <= (^shift) ^ par_bit;
`endif
            end
`ifdef UART_RX_PARITY_EN
            if (par_sample) par_bit <= rx_s;
`endif
        end
    end

    assign rx_busy = (state_q != IDLE) || div_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed bench: dut_a at 100 MHz default, dut_b with CLK_FREQ=960000 (100 clk/bit at reset).
`timescale 1ns/1ps
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
    localparam int NPB = 1;
`else
    localparam int NPB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rx_a, rx_b;
    logic [31:0] baud_a, baud_b;
    logic [7:0]  data_a, data_b;
    logic        done_a, done_b, ferr_a, ferr_b, busy_a, busy_b;
`ifdef UART_RX_PARITY_EN
    logic        perr_a, perr_b;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int busy_cnt_a = 0;
    int t0;
    int qc_a[$];
    int qc_b[$];
    logic [7:0] qd_a[$];
    logic [7:0] qd_b[$];

    always #5 clk = ~clk;

    uart_rx_core dut_a (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_a), .UART_RX(rx_a), .baud_rate(baud_a),
        .rx_data(data_a), .rx_done(done_a), .frame_error(ferr_a), .rx_busy(busy_a)
`ifdef UART_RX_PARITY_EN
        , .parity_error(perr_a)
`endif
    );

    uart_rx_core #(.CLK_FREQ(960_000)) dut_b (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_b), .UART_RX(rx_b), .baud_rate(baud_b),
        .rx_data(data_b), .rx_done(done_b), .frame_error(ferr_b), .rx_busy(busy_b)
`ifdef UART_RX_PARITY_EN
        , .parity_error(perr_b)
`endif
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (busy_a) busy_cnt_a++;
        if (done_a) begin qc_a.push_back(cyc); qd_a.push_back(data_a); end
        if (done_b) begin qc_b.push_back(cyc); qd_b.push_back(data_b); end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called at posedge+1; holds the line for n clocks and returns at posedge+1.
    task automatic drive(input bit w, input logic v, input int n);
        if (w) rx_b = v; else rx_a = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit w, input logic [7:0] d, input int bp, input logic stop);
        drive(w, 1'b0, bp);
        for (int i = 0; i < 8; i++) drive(w, d[i], bp);
`ifdef UART_RX_PARITY_EN
        drive(w, ^d, bp);
`endif
        drive(w, stop, bp);
    endtask

    // Line drive to rx_done: two synchroniser cycles plus the in-core latency.
    function automatic int lat(input int bp);
        return (bp >> 1) + (8 + 1 + NPB) * bp + 1 + 2;
    endfunction

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        baud_a = 32'd9600; baud_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_a", data_a, 8'h00);
        check("rst_done_a", done_a, 1'b0);
        check("rst_ferr_a", ferr_a, 1'b0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Reset bit period 10416: a rejected start bit keeps START busy for 10416>>1 cycles.
        busy_cnt_a = 0;
        drive(0, 1'b0, 100);
        rx_a = 1'b1;
        repeat (5300) @(posedge clk);
        #1;
        check("default_start_len", busy_cnt_a, 5208);
        check("default_glitch_nodone", qc_a.size(), 0);

        busy_cnt_a = 0;
        baud_a = 32'd10_000_000;
        repeat (60) @(posedge clk);
        #1;
        check("divide_busy_cycles", busy_cnt_a, 33);

        t0 = cyc;
        send(0, 8'h3C, 10, 1'b1);
        drive(0, 1'b1, 10);
        check("f3c_count", qc_a.size(), 1);
        check("f3c_data", qd_a[0], 8'h3C);
        check("f3c_latency", qc_a[0] - t0, lat(10));
        check("f3c_ferr", ferr_a, 1'b0);

        busy_cnt_a = 0;
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 30);
        check("glitch_nodone", qc_a.size(), 1);
        check("glitch_busy_len", busy_cnt_a, 5);
        check("glitch_busy_idle", busy_a, 1'b0);
        check("glitch_data", data_a, 8'h3C);

        send(0, 8'hFF, 10, 1'b0);
        drive(0, 1'b0, 50);
        check("break_count", qc_a.size(), 2);
        check("break_data", qd_a[1], 8'hFF);
        check("break_ferr", ferr_a, 1'b1);
        check("break_idle", busy_a, 1'b0);
        drive(0, 1'b1, 20);
        send(0, 8'h00, 10, 1'b1);
        drive(0, 1'b1, 10);
        check("after_break_count", qc_a.size(), 3);
        check("after_break_data", qd_a[2], 8'h00);
        check("after_break_ferr", ferr_a, 1'b0);

        send(0, 8'h55, 10, 1'b1);
        send(0, 8'hAA, 10, 1'b1);
        drive(0, 1'b1, 20);
        check("b2b_count", qc_a.size(), 5);
        check("b2b_first", qd_a[3], 8'h55);
        check("b2b_second", qd_a[4], 8'hAA);
        check("b2b_spacing", qc_a[4] - qc_a[3], (10 + NPB) * 10);

        t0 = cyc;
        send(1, 8'hA5, 100, 1'b1);
        drive(1, 1'b1, 20);
        check("fa5_count", qc_b.size(), 1);
        check("fa5_data", qd_b[0], 8'hA5);
        check("fa5_ferr", ferr_b, 1'b0);
        check("fa5_latency", qc_b[0] - t0, lat(100));

        // Abort a frame halfway through data bit 4.
        drive(1, 1'b0, 100);
        drive(1, 1'b1, 100);
        drive(1, 1'b0, 100);
        drive(1, 1'b1, 100);
        drive(1, 1'b0, 100);
        drive(1, 1'b1, 50);
        check("midframe_busy", busy_b, 1'b1);
        rst_b = 1'b0;
        #2;
        check("midrst_data", data_b, 8'h00);
        check("midrst_done", done_b, 1'b0);
        check("midrst_ferr", ferr_b, 1'b0);
        check("midrst_busy", busy_b, 1'b0);
        rx_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
        drive(1, 1'b1, 200);
        check("midrst_nodone", qc_b.size(), 1);
        send(1, 8'h81, 100, 1'b1);
        drive(1, 1'b1, 20);
        check("f81_count", qc_b.size(), 2);
        check("f81_data", qd_b[1], 8'h81);
        check("f81_ferr", ferr_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
